// File: rtl/fir_axil_ctrl.sv
// AXI-Lite control/configuration slave for the FIR engine.
// Holds the control register, the data-length register and the tap-coefficient
// file, issues a one-cycle start pulse to the datapath and collects its
// completion pulse. Taps are also exposed on a combinational lookup port.
module fir_axil_ctrl #(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned NUM_TAPS    = 11
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  // write-address channel
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  // write-data channel
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  // read-address channel
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  // read-data channel
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  // FIR datapath side
  output logic                   core_start,
  input  logic                   core_done,
  output logic [pDATA_WIDTH-1:0] data_length,
  input  logic [3:0]             coef_idx,
  output logic [pDATA_WIDTH-1:0] coef_data
);

  // Registers are decoded on the word address; addr[1:0] is ignored.
  localparam int unsigned WordW = pADDR_WIDTH - 2;
  localparam logic [WordW-1:0] CtrlWord = WordW'(0);
  localparam logic [WordW-1:0] LenWord  = WordW'(4);
  localparam int unsigned TapBase = 8;

  typedef enum logic {StIdle, StRun} ctrl_state_e;
  typedef enum logic {StRdIdle, StRdData} rd_state_e;

  // Write holding registers
  logic                   aw_held_q;
  logic                   w_held_q;
  logic [WordW-1:0]       aw_word_q;
  logic [pDATA_WIDTH-1:0] wdata_q;
  logic                   wr_commit;

  // Control state
  ctrl_state_e            ctrl_state_q, ctrl_state_d;
  logic                   ap_start_q, ap_start_d;
  logic                   ap_done_q, ap_done_d;
  logic                   ap_idle;

  // Configuration storage
  logic [pDATA_WIDTH-1:0] data_length_q;
  logic [pDATA_WIDTH-1:0] taps_q [NUM_TAPS];
  logic                   cfg_we;

  // Read path
  rd_state_e              rd_state_q, rd_state_d;
  logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                   rd_ctrl_q, rd_ctrl_d;
  logic [WordW-1:0]       ar_word;
  logic [pDATA_WIDTH-1:0] rd_mux;
  logic                   rd_done_ctrl;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{awaddr[1:0], araddr[1:0]};

  assign awready   = ~aw_held_q;
  assign wready    = ~w_held_q;
  assign wr_commit = aw_held_q & w_held_q;

  assign ap_idle    = (ctrl_state_q == StIdle);
  assign core_start = ap_start_q;
  // Config writes are only honoured while fully idle with no start pending.
  assign cfg_we     = wr_commit & ap_idle & ~ap_start_q;

  assign arready      = (rd_state_q == StRdIdle);
  assign rvalid       = (rd_state_q == StRdData);
  assign rdata        = rdata_q;
  assign rd_done_ctrl = rvalid & rready & rd_ctrl_q;
  assign ar_word      = araddr[pADDR_WIDTH-1:2];

  assign data_length = data_length_q;

  // Capture AW and W independently; both flags drop on the commit edge.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_word_q <= '0;
      wdata_q   <= '0;
    end else if (wr_commit) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
    end else begin
      if (awvalid && awready) begin
        aw_held_q <= 1'b1;
        aw_word_q <= awaddr[pADDR_WIDTH-1:2];
      end
      if (wvalid && wready) begin
        w_held_q <= 1'b1;
        wdata_q  <= wdata;
      end
    end
  end

  // Data-length and tap register file updates.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      data_length_q <= '0;
      for (int unsigned i = 0; i < NUM_TAPS; i++) begin
        taps_q[i] <= '0;
      end
    end else if (cfg_we) begin
      if (aw_word_q == LenWord) begin
        data_length_q <= wdata_q;
      end
      for (int unsigned i = 0; i < NUM_TAPS; i++) begin
        if (aw_word_q == WordW'(TapBase + i)) begin
          taps_q[i] <= wdata_q;
        end
      end
    end
  end

  // Control FSM state register.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      ctrl_state_q <= StIdle;
      ap_start_q   <= 1'b0;
      ap_done_q    <= 1'b0;
    end else begin
      ctrl_state_q <= ctrl_state_d;
      ap_start_q   <= ap_start_d;
      ap_done_q    <= ap_done_d;
    end
  end

  // Control FSM next state: start launches a run, done returns to idle.
  always_comb begin
    ctrl_state_d = ctrl_state_q;
    ap_start_d   = ap_start_q;
    ap_done_d    = ap_done_q;
    // Clear first so a coincident set below wins.
    if (rd_done_ctrl) begin
      ap_done_d = 1'b0;
    end
    unique case (ctrl_state_q)
      StIdle: begin
        if (ap_start_q) begin
          ap_start_d   = 1'b0;
          ctrl_state_d = StRun;
        end else if (wr_commit && (aw_word_q == CtrlWord) && wdata_q[0]) begin
          ap_start_d = 1'b1;
        end
      end
      StRun: begin
        if (core_done) begin
          ap_done_d    = 1'b1;
          ctrl_state_d = StIdle;
        end
      end
    endcase
  end

  // Read data selection from the current (pre-write) register values.
  always_comb begin
    rd_mux = '0;
    if (ar_word == CtrlWord) begin
      rd_mux[2:0] = {ap_idle, ap_done_q, ap_start_q};
    end else if (ar_word == LenWord) begin
      rd_mux = data_length_q;
    end else begin
      for (int unsigned i = 0; i < NUM_TAPS; i++) begin
        if (ar_word == WordW'(TapBase + i)) begin
          rd_mux = ap_idle ? taps_q[i] : '1;
        end
      end
    end
  end

  // Read FSM next state: register data on AR, hold until rready.
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rd_ctrl_d  = rd_ctrl_q;
    unique case (rd_state_q)
      StRdIdle: begin
        if (arvalid) begin
          rd_state_d = StRdData;
          rdata_d    = rd_mux;
          rd_ctrl_d  = (ar_word == CtrlWord);
        end
      end
      StRdData: begin
        if (rready) begin
          rd_state_d = StRdIdle;
        end
      end
    endcase
  end

  // Read FSM state register.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      rd_state_q <= StRdIdle;
      rdata_q    <= '0;
      rd_ctrl_q  <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rdata_q    <= rdata_d;
      rd_ctrl_q  <= rd_ctrl_d;
    end
  end

  // Combinational tap lookup for the datapath; out-of-range index reads 0.
  always_comb begin
    coef_data = '0;
    for (int unsigned i = 0; i < NUM_TAPS; i++) begin
      if (coef_idx == 4'(i)) begin
        coef_data = taps_q[i];
      end
    end
  end

endmodule

// File: tb/tb_fir_axil_ctrl.sv
// Self-checking bench for fir_axil_ctrl: a register-level model compared every
// cycle, plus directed transactions with literal expected read values.
module tb_fir_axil_ctrl;

  logic        clk;
  logic        rst;
  logic        awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
  logic [11:0] awaddr, araddr;
  logic [31:0] wdata, rdata;
  logic        core_start, core_done;
  logic [31:0] data_length, coef_data;
  logic [3:0]  coef_idx;

  int checks = 0;
  int failures = 0;

  fir_axil_ctrl #(
    .pADDR_WIDTH(12),
    .pDATA_WIDTH(32),
    .NUM_TAPS   (11)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .awvalid    (awvalid),
    .awready    (awready),
    .awaddr     (awaddr),
    .wvalid     (wvalid),
    .wready     (wready),
    .wdata      (wdata),
    .arvalid    (arvalid),
    .arready    (arready),
    .araddr     (araddr),
    .rvalid     (rvalid),
    .rready     (rready),
    .rdata      (rdata),
    .core_start (core_start),
    .core_done  (core_done),
    .data_length(data_length),
    .coef_idx   (coef_idx),
    .coef_data  (coef_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out waiting for handshake", name);
  endtask

  // ---------------- behavioural model ----------------
  logic        m_valid = 1'b0;
  logic        m_aw_held, m_w_held;
  logic [11:0] m_awaddr;
  logic [31:0] m_wdata;
  logic        m_start, m_done, m_idle;
  logic [31:0] m_len;
  logic [31:0] m_tap [11];
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        m_rd_ctrl;
  logic        pre_idle, pre_start, commit, clr, set_start;
  int unsigned mw;

  function automatic logic [31:0] m_read(input logic [11:0] a);
    int unsigned w;
    w = int'(a) / 4;
    if (w == 0) return {29'd0, m_idle, m_done, m_start};
    if (w == 4) return m_len;
    if (w >= 8 && w < 19) return m_idle ? m_tap[w - 8] : 32'hFFFF_FFFF;
    return 32'd0;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_aw_held = 0; m_w_held = 0; m_awaddr = 0; m_wdata = 0;
      m_start = 0; m_done = 0; m_idle = 1; m_len = 0;
      for (int i = 0; i < 11; i++) m_tap[i] = 0;
      m_rvalid = 0; m_rdata = 0; m_rd_ctrl = 0;
      m_valid = 1;
    end else if (m_valid) begin
      pre_idle  = m_idle;
      pre_start = m_start;
      commit    = m_aw_held && m_w_held;
      clr       = 0;
      set_start = 0;
      // reads see the register file before any write of this cycle
      if (!m_rvalid) begin
        if (arvalid) begin
          m_rdata   = m_read(araddr);
          m_rvalid  = 1;
          m_rd_ctrl = (int'(araddr) / 4 == 0);
        end
      end else if (rready) begin
        m_rvalid = 0;
        clr      = m_rd_ctrl;
      end
      if (commit) begin
        mw = int'(m_awaddr) / 4;
        if (pre_idle && !pre_start) begin
          if (mw == 4) m_len = m_wdata;
          if (mw >= 8 && mw < 19) m_tap[mw - 8] = m_wdata;
          if (mw == 0 && m_wdata[0]) set_start = 1;
        end
      end
      if (clr) m_done = 0;
      if (pre_idle) begin
        if (pre_start) begin
          m_start = 0;
          m_idle  = 0;
        end else if (set_start) begin
          m_start = 1;
        end
      end else if (core_done) begin
        m_idle = 1;
        m_done = 1;
      end
      if (commit) begin
        m_aw_held = 0;
        m_w_held  = 0;
      end else begin
        if (awvalid && !m_aw_held) begin m_aw_held = 1; m_awaddr = awaddr; end
        if (wvalid && !m_w_held) begin m_w_held = 1; m_wdata = wdata; end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("awready", {31'd0, awready}, {31'd0, !m_aw_held});
      check("wready", {31'd0, wready}, {31'd0, !m_w_held});
      check("arready", {31'd0, arready}, {31'd0, !m_rvalid});
      check("rvalid", {31'd0, rvalid}, {31'd0, m_rvalid});
      if (m_rvalid) check("rdata", rdata, m_rdata);
      check("core_start", {31'd0, core_start}, {31'd0, m_start});
      check("data_length", data_length, m_len);
      check("coef_data", coef_data, (coef_idx < 11) ? m_tap[coef_idx] : 32'd0);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    int n;
    step();
    awvalid = 1; awaddr = a; wvalid = 1; wdata = d;
    n = 0;
    while (!(awready && wready) && n < 20) begin step(); n++; end
    if (!(awready && wready)) timeout("write");
    step();
    awvalid = 0; wvalid = 0;
    step();
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string name);
    int n;
    step();
    arvalid = 1; araddr = a;
    n = 0;
    while (!arready && n < 20) begin step(); n++; end
    if (!arready) timeout(name);
    step();
    arvalid = 0;
    n = 0;
    while (!rvalid && n < 20) begin step(); n++; end
    if (!rvalid) timeout(name);
    check(name, rdata, exp);
    rready = 1;
    step();
    rready = 0;
  endtask

  int taps_vec [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

  initial begin
    rst = 0; awvalid = 0; wvalid = 0; arvalid = 0; rready = 0;
    awaddr = 0; araddr = 0; wdata = 0; core_done = 0; coef_idx = 0;

    // Reset
    step(); step();
    rst = 1;
    check("rst_awready", {31'd0, awready}, 32'd1);
    check("rst_wready", {31'd0, wready}, 32'd1);
    check("rst_arready", {31'd0, arready}, 32'd1);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rd(12'h000, 32'h4, "rst_ctrl");
    rd(12'h010, 32'h0, "rst_len");
    rd(12'h020, 32'h0, "rst_tap0");

    // Config
    wr(12'h010, 32'd64);
    for (int i = 0; i < 11; i++) wr(12'(32 + 4 * i), 32'(taps_vec[i]));
    rd(12'h010, 32'd64, "cfg_len");
    for (int i = 0; i < 11; i++) rd(12'(32 + 4 * i), 32'(taps_vec[i]), "cfg_tap");
    rd(12'h024, 32'hFFFF_FFF6, "cfg_tap1_lit");
    rd(12'h013, 32'd64, "cfg_len_lsbs");
    rd(12'h100, 32'd0, "unmapped");
    coef_idx = 4;
    step();
    check("coef4", coef_data, 32'd56);
    coef_idx = 12;
    step();
    check("coef12", coef_data, 32'd0);
    coef_idx = 1;

    // Handshake skew: W at cycle 0, AW at cycle 3
    step();
    wvalid = 1; wdata = 32'h55;
    step(); wvalid = 0;
    check("skew_wready1", {31'd0, wready}, 32'd0);
    step();
    check("skew_wready2", {31'd0, wready}, 32'd0);
    step();
    check("skew_wready3", {31'd0, wready}, 32'd0);
    awvalid = 1; awaddr = 12'h010;
    step(); awvalid = 0;
    check("skew_wready4", {31'd0, wready}, 32'd0);
    check("skew_len_before", data_length, 32'd64);
    step();
    check("skew_wready5", {31'd0, wready}, 32'd1);
    check("skew_len_after", data_length, 32'h55);
    rd(12'h010, 32'h55, "skew_read");

    // Start / done
    wr(12'h000, 32'd1);
    check("start_pulse_hi", {31'd0, core_start}, 32'd1);
    step();
    check("start_pulse_lo", {31'd0, core_start}, 32'd0);
    rd(12'h000, 32'h0, "run_ctrl");
    wr(12'h024, 32'd7);
    rd(12'h024, 32'hFFFF_FFFF, "run_tap");
    wr(12'h000, 32'd1);
    check("run_restart_ignored", {31'd0, core_start}, 32'd0);
    step();
    core_done = 1;
    step();
    core_done = 0;
    rd(12'h000, 32'h6, "done_ctrl");
    rd(12'h000, 32'h4, "done_cleared");
    rd(12'h024, 32'hFFFF_FFF6, "tap_kept");
    step();
    core_done = 1;
    step();
    core_done = 0;
    rd(12'h000, 32'h4, "done_in_idle");

    // Backpressure
    step();
    arvalid = 1; araddr = 12'h010;
    step(); arvalid = 0;
    for (int i = 0; i < 5; i++) begin
      check("bp_rvalid", {31'd0, rvalid}, 32'd1);
      check("bp_rdata", rdata, 32'h55);
      check("bp_arready", {31'd0, arready}, 32'd0);
      step();
    end
    rready = 1;
    step(); rready = 0;
    check("bp_arready_after", {31'd0, arready}, 32'd1);
    check("bp_rvalid_after", {31'd0, rvalid}, 32'd0);

    // Reset mid-run with AW held
    wr(12'h000, 32'd1);
    step();
    awvalid = 1; awaddr = 12'h010;
    step(); awvalid = 0;
    check("mid_aw_held", {31'd0, awready}, 32'd0);
    rst = 0;
    step(); step();
    rst = 1;
    check("mid_awready", {31'd0, awready}, 32'd1);
    check("mid_wready", {31'd0, wready}, 32'd1);
    check("mid_arready", {31'd0, arready}, 32'd1);
    check("mid_rvalid", {31'd0, rvalid}, 32'd0);
    check("mid_rdata", rdata, 32'd0);
    check("mid_core_start", {31'd0, core_start}, 32'd0);
    check("mid_len", data_length, 32'd0);
    wvalid = 1; wdata = 32'h99;
    step(); wvalid = 0;
    step(); step();
    check("mid_no_commit", data_length, 32'd0);
    rd(12'h010, 32'd0, "mid_len_read");
    rd(12'h000, 32'h4, "mid_ctrl_read");
    rd(12'h020, 32'd0, "mid_tap_read");

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fir_axil_ctrl.md
# fir_axil_ctrl

AXI-Lite configuration/control slave for the FIR engine, sitting directly downstream of the Wishbone-to-AXI bridge in the user project area. It terminates the bridge's AXI-Lite write/read channels and holds the FIR control register, the data-length register and an 11-entry tap-coefficient file. It drives a start pulse to the FIR datapath and collects its completion. Taps are exposed on a combinational read port.

## Interface
Parameters:
- pADDR_WIDTH, 12, AXI-Lite address width
- pDATA_WIDTH, 32, AXI-Lite data / register width
- NUM_TAPS, 11, number of coefficient registers

Ports:
- wb_clk_i  in  1  single clock; all state updates on rising edge
- wb_rst_i  in  1  reset, synchronous, active-low
- awvalid  in  1  / awready  out  1  / awaddr  in  pADDR_WIDTH: write-address channel
- wvalid  in  1  / wready  out  1  / wdata  in  pDATA_WIDTH: write-data channel
- arvalid  in  1  / arready  out  1  / araddr  in  pADDR_WIDTH: read-address channel
- rvalid  out  1  / rready  in  1  / rdata  out  pDATA_WIDTH: read-data channel
- core_start  out  1  one-cycle start pulse to FIR datapath
- core_done  in  1  one-cycle completion pulse from FIR datapath
- data_length  out  pDATA_WIDTH  sample count for the run
- coef_idx  in  4  tap index requested by datapath
- coef_data  out  pDATA_WIDTH  tap[coef_idx]; 0 if coef_idx >= NUM_TAPS

## Operation
- Register map (addr[1:0] ignored): 0x00 control; 0x10 data_length; 0x20+4*i tap[i], i=0..10. Other addresses: writes dropped, reads return 0.
- Control 0x00: bit0 ap_start, bit1 ap_done (sticky), bit2 ap_idle; bits 31:3 read 0. Only bit0 writable.
- Control FSM, two states:
  - IDLE (ap_idle=1): write to 0x00 with wdata[0]=1 sets ap_start. Next edge: ap_start->0, ap_idle->0, state->RUN. core_start = ap_start register, giving exactly one cycle high.
  - RUN: core_done=1 -> next edge ap_idle=1, ap_done=1, state->IDLE.
  - Writes of ap_start in RUN are ignored. core_done in IDLE is ignored.
- ap_done is cleared when a read of 0x00 completes (rvalid&rready). If set and clear coincide, set wins.
- data_length and taps are writable only while ap_idle=1 and ap_start=0; otherwise the write is accepted but dropped.
- Tap reads while not idle return 0xFFFFFFFF. data_length and control are always readable.
- Write path: AW and W are captured independently into holding registers. awready = !aw_held; wready = !w_held. When both are held, the register commits on the next edge, and both held flags clear on that same edge.
- No write-response channel; the commit is silent.
- Read path: arready=1 in R_IDLE. On AR handshake, rdata is registered and rvalid=1 (R_DATA). Hold rdata/rvalid stable until rready, then return to R_IDLE. Read and write paths are independent.
- A read and a write to the same register in the same cycle: rdata returns the pre-write value.

## Timing
- Reset (wb_rst_i=0 at an edge) values: awready=1, wready=1, arready=1, rvalid=0, rdata=0, core_start=0, data_length=0, all taps=0, ap_start=0, ap_done=0, ap_idle=1, FSMs idle.
- Reset mid-transaction discards held AW/W and any pending read.
- Write latency: handshake at edge E0 (both channels), register visible after E1. awready/wready are high again after E1, giving one write per 2 cycles sustained.
- AW before W (or W before AW): the commit occurs one edge after the later handshake.
- Read latency: AR handshake at E0, rvalid=1 after E0. The next AR is accepted the cycle after rready completes.
- ap_start write committed at E1 -> core_start high E1..E2 -> ap_idle=0 after E2.
- core_done at edge En -> ap_done=1 and ap_idle=1 after En.
- coef_data is combinational from coef_idx and the tap registers, with zero latency.

## Test plan
- Reset: hold wb_rst_i=0 for 2 cycles -> read 0x00 returns 0x4; 0x10 and 0x20 return 0; all readies =1; rvalid=0.
- Config: write 0x10=64, then taps 0x20..0x48 = 0,-10,-9,23,56,63,56,23,-9,-10,0 -> reads return the same values; coef_idx=4 gives coef_data=56; coef_idx=12 gives 0.
- Handshake skew: W at cycle 0, AW at cycle 3 to 0x10 = 0x55 -> wready low cycles 1..4, commit after cycle 4, read returns 0x55.
- Start/done: write 0x00=1 -> one-cycle core_start; 0x00 reads 0x0. A tap write of 7 to 0x24 is dropped and the tap read returns 0xFFFFFFFF. Pulse core_done -> 0x00 reads 0x6, then the next read returns 0x4.
- Backpressure: AR to 0x10 with rready held low 5 cycles -> rvalid and rdata stable for all 5 cycles; arready low until the transfer completes.
- Reset mid-run: assert reset while in RUN with AW held -> all outputs return to reset values, and the pending write never commits.
